piso_buf_256b: RTL and testbench
================================

Name: piso_buf_256b

Overview:
- Parallel-in, serial-out 256-byte buffer; the transmit-side counterpart of the team's SIPO capture buffer.
- The host loads up to 64 32-bit words one at a time, then commands a scan that shifts all 2048 bits out on sout.
- It uses the same val_op/op/op_ack/op_commit/scaning command handshake as the SIPO buffer.
- It sits between the host word bus and a DUT scan-in chain.

Parameters:
- WORD_W, 32, parallel word width in bits.
- DEPTH, 64, number of buffer words (256 B).
- SCAN_BITS, 2048, bits shifted per scan (WORD_W*DEPTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- pin  input  32  word to store on a WRITE op.
- sout  output  1  serial scan data.
- val_op  input  1  op request valid (level).
- op  input  1  0 = WRITE, 1 = SCAN.
- scaning  output  1  high while sout carries valid scan bits.
- op_ack  output  1  one-cycle pulse: op accepted.
- op_commit  output  1  one-cycle pulse: op finished.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - Write pointer, read pointer and bit counter clear to 0.
  - Shift register clears.
  - sout=0, scaning=0, op_ack=0, op_commit=0.
  - Memory contents are not cleared.
- FSM states: IDLE, WACK, SPRE, SHIFT, SDONE.
- All outputs are registered or decoded from state only; none depends combinationally on val_op.
- IDLE:
  - val_op=1, op=0 at edge E: mem[wptr]<=pin, wptr<=wptr+1, go to WACK.
  - val_op=1, op=1 at edge E: issue synchronous read of word 0, rptr<=1, go to SPRE.
- WACK (1 cycle): op_ack=1 and op_commit=1, then go to IDLE.
- SPRE (1 cycle): op_ack=1. At the next edge, the shift register loads word 0, the read of word 1 is issued, and the FSM goes to SHIFT.
- SHIFT:
  - scaning=1; sout = shift register bit 0.
  - Each edge shifts right by 1 and increments the 11-bit bit counter.
  - At bit counter%32==31, the shift register instead loads the prefetched next word, so there are no bubbles.
  - Output is exactly 2048 contiguous scaning cycles: word 0 first, LSB first.
  - After bit 2047, go to SDONE.
- SDONE (1 cycle): op_commit=1, scaning=0, wptr<=0; go to IDLE.
- Overall SCAN latency: op_ack 1 cycle after accept; first bit 2 cycles after accept; op_commit 2050 cycles after accept.
- The requester must drop val_op in the op_ack cycle. val_op still high in IDLE is taken as a new op.
- val_op is ignored in WACK, SPRE, SHIFT and SDONE: no ack, no write, no pointer change.
- sout=0 whenever scaning=0.
- wptr wraps 63->0. A 65th WRITE without an intervening SCAN overwrites word 0. There is no full flag.
- SCAN always emits all 64 words. Words not written since reset are undefined content.
- Reset mid-scan: scaning and sout drop immediately (asynchronous). No op_commit is issued. After release the block is in IDLE with wptr=0.
- Memory is single-port-write / synchronous-read. A write and a read never occur in the same cycle, by construction of the FSM.

Decomposition:
- Package piso_buf_pkg holds:
  - the state enum {IDLE, WACK, SPRE, SHIFT, SDONE};
  - WORD_W, DEPTH, SCAN_BITS;
  - PTR_W=6 and CNT_W=11.
- Split into two sub-modules, mirroring the SIPO buffer:
  - piso_buf_256b_ctrl: FSM, handshake outputs, control strobes addrclr/ld/sften/mem_wen/mem_ren.
  - piso_buf_256b_datapath: memory, pointers, bit counter, shift register.
- Top level instantiates only these two.

Test Plan:
- Reset: hold reset=0 3 cycles with val_op=1 -> sout, scaning, op_ack and op_commit all 0; after release, no ack until val_op is sampled in IDLE.
- Full load+scan:
  - Stimulus: WRITE words i*0x01010101 (i=0..63), then SCAN.
  - Required: each WRITE gives op_ack=op_commit=1 for exactly 1 cycle.
  - Required: SCAN op_ack 1 cycle after accept; scaning high 2048 contiguous cycles starting 2 cycles after accept.
  - Required: sout stream equals words 0..63 LSB-first; op_commit 2050 cycles after accept.
- Pattern check: WRITE 0xA5A5A5A5, 0x0000FFFF, 0x80000001 then SCAN -> first 96 sout bits are 1,0,1,0,0,1,0,1... then sixteen 1s/sixteen 0s, then 1, thirty 0s, 1.
- Busy ignore: assert val_op op=0 pin=0xDEADBEEF during SHIFT cycle 500 -> no op_ack; on the next scan, word 0 is unchanged.
- Wrap: 65 WRITEs (word k=k, 65th=0xFFFFFFFF) then SCAN -> first 32 sout bits all 1; bits 32..63 encode 1.
- Mid-scan reset: reset=0 at bit 1000 -> scaning and sout 0 within the same cycle, no op_commit; after release, WRITE 0x1 then SCAN -> sout bit 0 = 1.

Source files
------------

// File: rtl/piso_buf_256b_pkg.sv
// Shared types and sizing for the 256-byte parallel-in, serial-out scan buffer.
// The serial stream is 64 words of 32 bits, sent least significant bit first.
package piso_buf_pkg;

  localparam int WORD_W    = 32;
  localparam int DEPTH     = 64;
  localparam int SCAN_BITS = WORD_W * DEPTH;
  localparam int PTR_W     = 6;
  localparam int CNT_W     = 11;
  // Low bits of the bit counter that index a bit within one word.
  localparam int BIT_W     = $clog2(WORD_W);

  typedef enum logic [2:0] {
    IDLE,
    WACK,
    SPRE,
    SHIFT,
    SDONE
  } state_t;

endpackage

// File: rtl/piso_buf_256b_if.sv
// Host-side command and data bundle for the scan buffer.
// The host (master) drives the op request and word; the buffer (slave) returns the handshake and serial data.
interface piso_buf_256b_if;
  import piso_buf_pkg::*;

  logic              val_op;
  logic              op;
  logic [WORD_W-1:0] pin;
  logic              op_ack;
  logic              op_commit;
  logic              scaning;
  logic              sout;

  modport master (
    output val_op,
    output op,
    output pin,
    input  op_ack,
    input  op_commit,
    input  scaning,
    input  sout
  );

  modport slave (
    input  val_op,
    input  op,
    input  pin,
    output op_ack,
    output op_commit,
    output scaning,
    output sout
  );

endinterface

// File: rtl/piso_buf_256b_ctrl.sv
// Command FSM for the scan buffer: it accepts WRITE and SCAN ops, pulses ack and commit,
// and sequences the memory and shift-register strobes so that a scan has no gaps.
module piso_buf_256b_ctrl
  import piso_buf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_val_op,
  input  logic i_op,
  input  logic i_word_end,
  input  logic i_cnt_last,
  output logic o_op_ack,
  output logic o_op_commit,
  output logic o_scaning,
  output logic o_addrclr,
  output logic o_ld,
  output logic o_sften,
  output logic o_mem_wen,
  output logic o_mem_ren
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The handshake outputs are decoded from the state only. val_op affects only the next state and the strobes.
  always_comb begin
    w_next      = r_state;
    o_op_ack    = 1'b0;
    o_op_commit = 1'b0;
    o_scaning   = 1'b0;
    o_addrclr   = 1'b0;
    o_ld        = 1'b0;
    o_sften     = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_ren   = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_val_op) begin
          if (i_op) begin
            o_mem_ren = 1'b1;
            w_next    = SPRE;
          end else begin
            o_mem_wen = 1'b1;
            w_next    = WACK;
          end
        end
      end

      WACK: begin
        o_op_ack    = 1'b1;
        o_op_commit = 1'b1;
        w_next      = IDLE;
      end

      SPRE: begin
        o_op_ack  = 1'b1;
        o_ld      = 1'b1;
        o_mem_ren = 1'b1;
        w_next    = SHIFT;
      end

      SHIFT: begin
        o_scaning = 1'b1;
        o_sften   = 1'b1;
        // On the last bit of each word, load the prefetched word instead of shifting.
        // This keeps the stream continuous. No prefetch is needed after the final word.
        if (i_word_end && !i_cnt_last) begin
          o_ld      = 1'b1;
          o_mem_ren = 1'b1;
        end
        if (i_cnt_last) begin
          w_next = SDONE;
        end
      end

      SDONE: begin
        o_op_commit = 1'b1;
        o_addrclr   = 1'b1;
        w_next      = IDLE;
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/piso_buf_256b_datapath.sv
// Storage and serialisation for the scan buffer: word memory with a registered read,
// write and read pointers, the scan bit counter, and the output shift register.
module piso_buf_256b_datapath
  import piso_buf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] i_pin,
  input  logic              i_addrclr,
  input  logic              i_ld,
  input  logic              i_sften,
  input  logic              i_mem_wen,
  input  logic              i_mem_ren,
  output logic              o_word_end,
  output logic              o_cnt_last,
  output logic              o_sout
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] r_shift;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;

  // Memory contents survive reset. The FSM never requests a write and a read in the same cycle.
  always_ff @(posedge clk) begin
    if (i_mem_wen) begin
      r_mem[r_wptr] <= i_pin;
    end
    if (i_mem_ren) begin
      r_rdata <= r_mem[r_rptr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_addrclr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_mem_wen) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (i_mem_ren) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (i_sften) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
    end else if (i_ld) begin
      r_shift <= r_rdata;
    end else if (i_sften) begin
      r_shift <= {1'b0, r_shift[WORD_W-1:1]};
    end
  end

  assign o_word_end = &r_cnt[BIT_W-1:0];
  assign o_cnt_last = (r_cnt == CNT_W'(SCAN_BITS - 1));
  // The shift-enable is high only in SHIFT, so it also forces sout low outside a scan.
  assign o_sout     = i_sften & r_shift[0];

endmodule

// File: rtl/piso_buf_256b.sv
// Top level of the 256-byte parallel-in, serial-out scan buffer.
// It joins the command FSM to the memory and shift datapath.
module piso_buf_256b (
  input  logic            clk,
  input  logic            reset,
  piso_buf_256b_if.slave  bus
);

  logic w_addrclr;
  logic w_ld;
  logic w_sften;
  logic w_mem_wen;
  logic w_mem_ren;
  logic w_word_end;
  logic w_cnt_last;

  piso_buf_256b_ctrl u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .i_val_op    (bus.val_op),
    .i_op        (bus.op),
    .i_word_end  (w_word_end),
    .i_cnt_last  (w_cnt_last),
    .o_op_ack    (bus.op_ack),
    .o_op_commit (bus.op_commit),
    .o_scaning   (bus.scaning),
    .o_addrclr   (w_addrclr),
    .o_ld        (w_ld),
    .o_sften     (w_sften),
    .o_mem_wen   (w_mem_wen),
    .o_mem_ren   (w_mem_ren)
  );

  piso_buf_256b_datapath u_datapath (
    .clk        (clk),
    .reset      (reset),
    .i_pin      (bus.pin),
    .i_addrclr  (w_addrclr),
    .i_ld       (w_ld),
    .i_sften    (w_sften),
    .i_mem_wen  (w_mem_wen),
    .i_mem_ren  (w_mem_ren),
    .o_word_end (w_word_end),
    .o_cnt_last (w_cnt_last),
    .o_sout     (bus.sout)
  );

endmodule

// File: tb/tb_piso_buf_256b.sv
// Scoreboard bench for piso_buf_256b. The driver queues the expected ack and commit cycles,
// the scan window and the serial bits. A negedge monitor compares them against the buffer every cycle.
module tb_piso_buf_256b;
  import piso_buf_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  piso_buf_256b_if bus ();

  piso_buf_256b dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int   ack_q[$];
  int   commit_q[$];
  logic bit_q[$];
  int   win_lo = 1;
  int   win_hi = 0;

  logic [WORD_W-1:0] mdl [DEPTH];
  int                mwp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle, compare the handshake pulses, the scan window and the serial data.
  always @(negedge clk) begin
    logic e_ack;
    logic e_com;
    logic e_scan;
    logic b;
    e_ack  = (ack_q.size() > 0) && (ack_q[0] == cyc);
    e_com  = (commit_q.size() > 0) && (commit_q[0] == cyc);
    e_scan = (cyc >= win_lo) && (cyc <= win_hi);
    check("op_ack", 32'(bus.op_ack), 32'(e_ack));
    check("op_commit", 32'(bus.op_commit), 32'(e_com));
    check("scaning", 32'(bus.scaning), 32'(e_scan));
    if (e_ack) void'(ack_q.pop_front());
    if (e_com) void'(commit_q.pop_front());
    if (bus.scaning) begin
      if (bit_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sout_extra cyc=%0d got=%0b want=no_bit", cyc, bus.sout);
      end else begin
        b = bit_q.pop_front();
        check("sout", 32'(bus.sout), 32'(b));
      end
    end else begin
      check("sout_idle", 32'(bus.sout), 32'd0);
    end
  end

  task automatic write_word(input logic [WORD_W-1:0] w);
    bus.val_op = 1'b1;
    bus.op     = 1'b0;
    bus.pin    = w;
    @(posedge clk);
    #1;
    ack_q.push_back(cyc);
    commit_q.push_back(cyc);
    mdl[mwp] = w;
    mwp = (mwp + 1) % DEPTH;
    bus.val_op = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input int busy_at, input int rst_at);
    int acc;
    bus.val_op = 1'b1;
    bus.op     = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    bus.val_op = 1'b0;
    bus.op     = 1'b0;
    ack_q.push_back(acc);
    win_lo = acc + 1;
    win_hi = acc + SCAN_BITS;
    for (int w = 0; w < DEPTH; w++)
      for (int k = 0; k < WORD_W; k++)
        bit_q.push_back(mdl[w][k]);
    if (rst_at < 0) commit_q.push_back(acc + SCAN_BITS + 1);

    if (busy_at >= 0) begin
      while (cyc < acc + 1 + busy_at) begin
        @(posedge clk);
        #1;
      end
      bus.val_op = 1'b1;
      bus.op     = 1'b0;
      bus.pin    = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      bus.val_op = 1'b0;
    end

    if (rst_at >= 0) begin
      while (cyc < acc + 1 + rst_at) begin
        @(posedge clk);
        #1;
      end
      reset  = 1'b0;
      win_hi = cyc - 1;
      #1;
      check("rst_mid_scaning", 32'(bus.scaning), 32'd0);
      check("rst_mid_sout", 32'(bus.sout), 32'd0);
      bit_q.delete();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      mwp   = 0;
      repeat (2) @(posedge clk);
      #1;
    end else begin
      while (cyc < acc + SCAN_BITS + 2) begin
        @(posedge clk);
        #1;
      end
      mwp = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    bus.val_op = 1'b1;
    bus.op     = 1'b0;
    bus.pin    = 32'h12345678;
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sout", 32'(bus.sout), 32'd0);
    check("rst_scaning", 32'(bus.scaning), 32'd0);
    check("rst_op_ack", 32'(bus.op_ack), 32'd0);
    check("rst_op_commit", 32'(bus.op_commit), 32'd0);
    reset      = 1'b1;
    bus.val_op = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++) write_word(32'(i) * 32'h01010101);
    scan(-1, -1);

    write_word(32'hA5A5A5A5);
    write_word(32'h0000FFFF);
    write_word(32'h80000001);
    scan(500, -1);
    scan(-1, -1);

    for (int k = 0; k < DEPTH; k++) write_word(32'(k));
    write_word(32'hFFFFFFFF);
    scan(-1, -1);

    scan(-1, 1000);
    write_word(32'h00000001);
    scan(-1, -1);

    repeat (5) @(posedge clk);
    #1;
    check("ack_q_left", 32'(ack_q.size()), 32'd0);
    check("commit_q_left", 32'(commit_q.size()), 32'd0);
    check("bit_q_left", 32'(bit_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
